// File: rtl/cgra_pc_fetch.sv
// PC register, instruction store and fetch/decode front end for one CGRA processing element.
// The store is read at the next PC so that pc and instr always advance together.
module cgra_pc_fetch #(
   parameter int unsigned PC_W    = 12,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_wdata,
   input  logic               clken_PC,
   input  logic               load_PC,
   input  logic               incr_PC,
   input  logic [PC_W-1:0]    load_value_PC,
   input  logic               vec_step,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               is_not_vect,
   output logic               is_bne,
   output logic               is_vstreamout,
   output logic [PC_W-1:0]    branch_immediate,
   output logic               done_auto_incr,
   output logic [PC_W-1:0]    vec_idx,
   output logic               halted
);

   localparam int unsigned Depth = 2 ** PC_W;
   localparam int unsigned VW    = (PC_W > 12) ? PC_W : 12;

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    vec_idx_q, vec_idx_d;
   logic [INSTR_W-1:0] instr_q;
   logic               halted_q, halted_d;

   logic [INSTR_W-1:0] mem [Depth];

   logic               fetch_en;
   logic [PC_W-1:0]    fetch_addr;
   logic               mem_we;

   logic [3:0]         op;
   logic [11:0]        vlen;
   logic [11:0]        vlen_last;
   logic [VW-1:0]      idx_ext;
   logic [VW-1:0]      last_ext;
   logic               run;
   logic               is_vec;
   logic               done;
   logic               pc_move;

   assign op        = instr_q[31:28];
   assign vlen      = instr_q[27:16];
   assign is_vec    = op[3];
   assign run       = (state_q == StRun);
   // A vlen of 0 behaves like a single-element vector.
   assign vlen_last = (vlen == 12'd0) ? 12'd0 : vlen - 12'd1;
   assign idx_ext   = VW'(vec_idx_q);
   assign last_ext  = VW'(vlen_last);
   assign done      = run & is_vec & (idx_ext == last_ext);
   assign pc_move   = clken_PC & (load_PC | incr_PC);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      vec_idx_d  = vec_idx_q;
      halted_d   = halted_q;
      fetch_en   = 1'b0;
      fetch_addr = pc_q;
      mem_we     = 1'b0;
      unique case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d    = StRun;
               pc_d       = '0;
               vec_idx_d  = '0;
               halted_d   = 1'b0;
               fetch_en   = 1'b1;
               fetch_addr = '0;
            end else begin
               mem_we = prog_we;
            end
         end
         StRun: begin
            if (op == 4'hF) begin
               // HALT freezes pc, instr and the element index where they stand.
               state_d  = StHalt;
               halted_d = 1'b1;
            end else begin
               if (clken_PC & load_PC) begin
                  pc_d = load_value_PC;
               end else if (clken_PC & incr_PC) begin
                  pc_d = pc_q + PC_W'(1);
               end
               if (pc_move) begin
                  vec_idx_d = '0;
               end else if (vec_step & is_vec & ~done) begin
                  vec_idx_d = vec_idx_q + PC_W'(1);
               end
               fetch_en   = 1'b1;
               fetch_addr = pc_d;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         vec_idx_q <= '0;
         instr_q   <= '0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         vec_idx_q <= vec_idx_d;
         halted_q  <= halted_d;
         if (fetch_en) begin
            instr_q <= mem[fetch_addr];
         end
      end
   end

   // Store contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_addr] <= prog_wdata;
      end
   end

   assign pc               = pc_q;
   assign instr            = instr_q;
   assign instr_valid      = run;
   assign is_not_vect      = run ? ~op[3] : 1'b1;
   assign is_bne           = run & (op == 4'h2);
   assign is_vstreamout    = run & (op == 4'hA);
   assign branch_immediate = instr_q[PC_W-1:0];
   assign done_auto_incr   = done;
   assign vec_idx          = vec_idx_q;
   assign halted           = halted_q;

endmodule

// File: tb/tb_cgra_pc_fetch.sv
// Bench for cgra_pc_fetch: directed scenarios then random strobes, all checked each cycle
// against a behavioural model of the PE front end.
module tb_cgra_pc_fetch;

   localparam int unsigned DEPTH     = 4096;
   localparam int unsigned HALT_ADDR = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [11:0] prog_addr = '0;
   logic [31:0] prog_wdata = '0;
   logic        clken_PC = 1'b0;
   logic        load_PC = 1'b0;
   logic        incr_PC = 1'b0;
   logic [11:0] load_value_PC = '0;
   logic        vec_step = 1'b0;
   logic [11:0] pc;
   logic [31:0] instr;
   logic        instr_valid, is_not_vect, is_bne, is_vstreamout;
   logic [11:0] branch_immediate;
   logic        done_auto_incr;
   logic [11:0] vec_idx;
   logic        halted;

   cgra_pc_fetch #(.PC_W(12), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .clken_PC(clken_PC), .load_PC(load_PC), .incr_PC(incr_PC),
      .load_value_PC(load_value_PC), .vec_step(vec_step), .pc(pc), .instr(instr),
      .instr_valid(instr_valid), .is_not_vect(is_not_vect), .is_bne(is_bne),
      .is_vstreamout(is_vstreamout), .branch_immediate(branch_immediate),
      .done_auto_incr(done_auto_incr), .vec_idx(vec_idx), .halted(halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model
   bit [31:0]   mm [DEPTH];
   bit          m_run, m_halted;
   int unsigned m_pc, m_vidx;
   bit [31:0]   m_instr;

   function automatic int unsigned vlen_of(bit [31:0] w);
      int unsigned v = (w >> 16) & 32'hFFF;
      return (v == 0) ? 1 : v;
   endfunction

   function automatic bit model_done();
      return m_run && (m_instr >> 28) >= 8 && m_vidx == vlen_of(m_instr) - 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int unsigned op = m_instr >> 28;
      check("pc", pc, m_pc);
      check("instr", instr, m_instr);
      check("instr_valid", instr_valid, m_run);
      check("is_not_vect", is_not_vect, m_run ? (op < 8) : 1);
      check("is_bne", is_bne, m_run && op == 2);
      check("is_vstreamout", is_vstreamout, m_run && op == 10);
      check("branch_immediate", branch_immediate, m_instr % DEPTH);
      check("done_auto_incr", done_auto_incr, model_done());
      check("vec_idx", vec_idx, m_vidx);
      check("halted", halted, m_halted);
   endtask

   task automatic model_reset();
      m_run = 0; m_halted = 0; m_pc = 0; m_instr = 0; m_vidx = 0;
   endtask

   task automatic tick();
      bit          n_run = m_run;
      bit          n_halted = m_halted;
      int unsigned n_pc = m_pc;
      int unsigned n_vidx = m_vidx;
      bit [31:0]   n_instr = m_instr;
      bit          do_wr = 0;
      bit          moved;
      int unsigned wa = prog_addr;
      bit [31:0]   wd = prog_wdata;
      int unsigned op = m_instr >> 28;
      if (!m_run) begin
         if (start) begin
            n_run = 1; n_pc = 0; n_vidx = 0; n_halted = 0; n_instr = mm[0];
         end else if (prog_we) begin
            do_wr = 1;
         end
      end else if (op == 15) begin
         n_run = 0; n_halted = 1;
      end else begin
         moved = clken_PC && (load_PC || incr_PC);
         if (clken_PC && load_PC) n_pc = load_value_PC;
         else if (clken_PC && incr_PC) n_pc = (m_pc + 1) % DEPTH;
         if (moved) n_vidx = 0;
         else if (vec_step && op >= 8 && m_vidx < vlen_of(m_instr) - 1) n_vidx = m_vidx + 1;
         n_instr = mm[n_pc];
      end
      @(posedge clk);
      #1;
      if (do_wr) mm[wa] = wd;
      m_run = n_run; m_halted = n_halted; m_pc = n_pc; m_vidx = n_vidx; m_instr = n_instr;
      check_all();
   endtask

   task automatic drive(input bit s, input bit ck, input bit ld, input bit inc,
                        input int unsigned lv, input bit vs);
      start = s; clken_PC = ck; load_PC = ld; incr_PC = inc;
      load_value_PC = 12'(lv); vec_step = vs; prog_we = 0;
   endtask

   task automatic wr(input int unsigned a, input bit [31:0] d);
      drive(0, 0, 0, 0, 0, 0);
      prog_we = 1; prog_addr = 12'(a); prog_wdata = d;
      tick();
      prog_we = 0;
   endtask

   task automatic go();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      start = 0;
   endtask

   task automatic halt_out();
      drive(0, 1, 1, 0, HALT_ADDR, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      bit [31:0] w;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rst = 0;

      // Fill the whole store; op fields random, vector lengths kept short.
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         w[27:16] = 12'($urandom_range(0, 5));
         if (i == HALT_ADDR) w = 32'hF000_0000;
         wr(i, w);
      end

      // Straight line to HALT
      for (int i = 0; i < 4; i++) wr(i, 32'h1000_0000 + i);
      wr(4, 32'hF000_0000);
      go();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 0, 1, 0, 0);
         tick();
      end
      check("sl_pc_hold", pc, 4);
      check("sl_halted", halted, 1);
      check("sl_valid", instr_valid, 0);

      // Branch, no bubble, load beats incr
      wr(2, 32'h2000_0000);
      go();
      drive(0, 1, 0, 1, 0, 0); tick();
      drive(0, 1, 0, 1, 0, 0); tick();
      check("br_is_bne", is_bne, 1);
      drive(0, 1, 1, 0, 0, 0); tick();
      check("br_pc", pc, 0);
      check("br_instr", instr, 32'h1000_0000);
      drive(0, 1, 1, 1, 3, 0); tick();
      check("br_load_wins", pc, 3);
      halt_out();

      // Vector of 4 elements, PC advances on done
      wr(0, 32'h8004_0000);
      go();
      for (int i = 0; i < 5; i++) begin
         drive(0, model_done(), 0, model_done(), 0, 1);
         tick();
         if (i == 2) check("vec_done_at3", done_auto_incr, 1);
      end
      check("vec_pc", pc, 1);
      check("vec_idx_clr", vec_idx, 0);
      halt_out();
      wr(0, 32'h8000_0000);
      go();
      check("vlen0_done", done_auto_incr, 1);
      drive(0, 0, 0, 0, 0, 1); tick();
      check("vlen0_hold", vec_idx, 0);
      halt_out();

      // PC wrap
      wr(0, 32'h2000_0FFF);
      wr(12'hFFF, 32'h1234_5678);
      go();
      drive(0, 1, 1, 0, 12'hFFF, 0); tick();
      check("wrap_top", pc, 12'hFFF);
      drive(0, 1, 0, 1, 0, 0); tick();
      check("wrap_pc", pc, 0);
      halt_out();

      // Store writes dropped in RUN, honoured in HALT
      wr(5, 32'h1000_0005);
      go();
      drive(0, 0, 0, 0, 0, 0);
      prog_we = 1; prog_addr = 5; prog_wdata = 32'h3000_0055;
      tick();
      prog_we = 0;
      drive(0, 1, 1, 0, 5, 0); tick();
      check("we_run_dropped", instr, 32'h1000_0005);
      halt_out();
      wr(5, 32'h3000_0055);
      go();
      check("restart_pc", pc, 0);
      drive(0, 1, 1, 0, 5, 0); tick();
      check("we_halt_taken", instr, 32'h3000_0055);
      halt_out();

      // Async reset mid-vector
      wr(0, 32'h8004_0000);
      go();
      drive(0, 0, 0, 0, 0, 1); tick();
      tick();
      check("pre_rst_idx", vec_idx, 2);
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst = 1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst = 0;
      go();
      check("post_rst_instr", instr, 32'h8004_0000);

      // Random strobes, restarts and store writes
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
               $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) begin
            prog_we = 1;
            prog_addr = 12'($urandom_range(HALT_ADDR + 1, DEPTH - 1));
            prog_wdata = $urandom;
            prog_wdata[27:16] = 12'($urandom_range(0, 5));
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cgra_pc_fetch.md
# cgra_pc_fetch

Program-counter register, instruction store and fetch/decode front end for one CGRA processing element. It consumes the PC control strobes (`clken_PC`, `load_PC`, `incr_PC`, `load_value_PC`) from the PE's PC control logic. It returns the decoded fields that logic needs (`is_not_vect`, `is_bne`, `is_vstreamout`, `branch_immediate`) and the vector auto-increment completion flag `done_auto_incr`, closing the PC loop.

## Interface
Parameters:
- `PC_W`, 12: PC and branch-target width; the instruction store holds 2^PC_W words.
- `INSTR_W`, 32: instruction width. Minimum 32.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  1-cycle pulse; begins execution at PC 0.
- `prog_we`  in  1  instruction-store write enable.
- `prog_addr`  in  PC_W  write address.
- `prog_wdata`  in  INSTR_W  write data.
- `clken_PC`  in  1  PC update enable.
- `load_PC`  in  1  load the branch target; priority over `incr_PC`.
- `incr_PC`  in  1  increment the PC.
- `load_value_PC`  in  PC_W  branch target.
- `vec_step`  in  1  advance the vector element index.
- `pc`  out  PC_W  current PC.
- `instr`  out  INSTR_W  instruction at `pc`.
- `instr_valid`  out  1  `instr` is live (state RUN).
- `is_not_vect`  out  1  decoded: scalar instruction.
- `is_bne`  out  1  decoded: branch-not-equal.
- `is_vstreamout`  out  1  decoded: vector stream-out.
- `branch_immediate`  out  PC_W  `instr[PC_W-1:0]`.
- `done_auto_incr`  out  1  vector instruction on its last element.
- `vec_idx`  out  PC_W  current vector element index.
- `halted`  out  1  HALT instruction reached.

## Operation
- Instruction fields:
  - `op = instr[31:28]`; `op[3]=1` means vector.
  - Opcode values: `0x2` BNE, `0xA` VSTREAMOUT, `0xF` HALT.
  - `vlen = instr[27:16]`; a `vlen` of 0 is treated as 1.
  - `branch_immediate` is an absolute target.
- The FSM has three states: IDLE, RUN, HALT. Reset state is IDLE.
  - IDLE or HALT with `start` → RUN. On that edge: `pc<=0`, `instr<=mem[0]`, `vec_idx<=0`, `halted<=0`.
  - RUN with `op==0xF` → HALT. On that edge: `halted<=1`; PC and `instr` are frozen.
  - `start` in RUN is ignored.
- Next-PC, evaluated in RUN only:
  - If `clken_PC & load_PC`: next-PC = `load_value_PC`.
  - Else if `clken_PC & incr_PC`: next-PC = `pc+1`, wrapping modulo 2^PC_W.
  - Otherwise: next-PC = `pc`.
  - In IDLE/HALT, all PC strobes are ignored.
- Fetch:
  - The synchronous store is read at next-PC (combinational address).
  - `pc` and `instr` update on the same edge, so `instr` always equals `mem[pc]`. There is no fetch bubble, including on taken branches.
- Decode outputs:
  - When `instr_valid=1`: `is_not_vect=!op[3]`, `is_bne=(op==2)`, `is_vstreamout=(op==0xA)`.
  - When `instr_valid=0`: `is_not_vect=1`, `is_bne=0`, `is_vstreamout=0`.
  - `branch_immediate` is always `instr[PC_W-1:0]`.
- Vector counter:
  - `done_auto_incr = instr_valid & op[3] & (vec_idx == max(vlen,1)-1)`.
  - `vec_step` with a vector instruction and not done: `vec_idx++`.
  - `vec_idx<=0` on any PC change (load or incr applied), and on `start`.
  - `vec_step` on the last element holds `vec_idx`; it does not wrap.
  - `vec_step` is ignored for scalar instructions.
- Program store writes:
  - `prog_we` is honored only in IDLE or HALT, and not in a cycle with `start`.
  - Writes in RUN are dropped.

## Timing
- Reset values: `pc=0`, `instr=0`, `instr_valid=0`, `is_not_vect=1`, `is_bne=0`, `is_vstreamout=0`, `branch_immediate=0`, `done_auto_incr=0`, `vec_idx=0`, `halted=0`.
- `start` at edge t → `instr_valid=1` and `instr=mem[0]` visible after edge t.
- PC strobes sampled at edge t → new `pc`/`instr` visible after edge t, i.e. 1-cycle PC-to-decode latency.
- `load_PC` and `incr_PC` both high with `clken_PC`: load wins.
- HALT is decoded in the cycle it is fetched. `halted=1` and `instr_valid=0` after the next edge. `pc` stays at the HALT address.
- A write to `mem[a]` at edge t is readable by a fetch at edge t+1.
- Asserting `rst` mid-RUN forces all outputs to their reset values immediately. Store contents are not cleared.

## Test plan
- Straight line: load mem[0..3]=scalar ops, mem[4]=HALT; `start`; hold `clken_PC=incr_PC=1` → `pc` 0,1,2,3,4; `halted=1` one cycle after pc=4; `pc` stays 4.
- Branch: mem[2]=BNE with target 0x000; at pc=2 drive `load_PC=1`, `load_value_PC=0` → next cycle `pc=0`, `instr=mem[0]`, no bubble. Also drive `load_PC=incr_PC=1` → load wins.
- Vector: mem[0]=op 0x8, vlen=4; `vec_step` every cycle, with `clken_PC=incr_PC=done_auto_incr` → `vec_idx` 0,1,2,3; `done_auto_incr` high only at `vec_idx=3`; then `pc=1`, `vec_idx=0`. Also vlen=0 → done at `vec_idx=0`.
- Wrap: mem[0xFFF] scalar, branch to 0xFFF, then incr → `pc=0x000`.
- Store-write gating: `prog_we` to addr 5 during RUN → mem[5] unchanged on later fetch; the same write in HALT takes effect; `start` from HALT restarts at pc=0.
- Async reset mid-vector (vec_idx=2) → all outputs at reset values immediately, state IDLE; `start` resumes at pc=0 with program intact.
